cu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute control unit for the 8-bit accumulator CPU. Sits directly upstream of the ALU.
- Owns PC and IR.
- Sequences the single-port instruction/data memory.
- Drives alu_op, alu_en and alu_operand into the ALU.
- Drives write-enable/select for the accumulator register (lives in the CPU top).

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cu_decode.sv | 43 ++++
 rtl/cu_sequencer.sv | 127 ++++++++++++
 tb/tb_cu_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: widths, opcodes,
// ALU operation codes and the control-unit state encoding.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = DATA_W - 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUBI = 4'h6;
  localparam logic [3:0] OP_ANDI = 4'h7;
  localparam logic [3:0] OP_ORI  = 4'h8;
  localparam logic [3:0] OP_LDA  = 4'h9;
  localparam logic [3:0] OP_STA  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMRD,
    ST_EXEC,
    ST_MEMWR,
    ST_HALT
  } state_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: ALU operation, operand source, control
// flavour and the state that follows DECODE for this opcode.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_op,
  output logic       is_mem_operand,
  output logic       is_imm,
  output logic       is_load,
  output logic       is_jump,
  output logic       is_jz,
  output state_t     next_state
);

  // Illegal opcodes (D, E) fall through to the NOP defaults.
  always_comb begin
    alu_op         = ALU_NONE;
    is_mem_operand = 1'b0;
    is_imm         = 1'b0;
    is_load        = 1'b0;
    is_jump        = 1'b0;
    is_jz          = 1'b0;
    next_state     = ST_FETCH;
    case (opcode)
      OP_ADD:  begin alu_op = ALU_ADD; is_mem_operand = 1'b1; next_state = ST_MEMRD; end
      OP_SUB:  begin alu_op = ALU_SUB; is_mem_operand = 1'b1; next_state = ST_MEMRD; end
      OP_AND:  begin alu_op = ALU_AND; is_mem_operand = 1'b1; next_state = ST_MEMRD; end
      OP_OR:   begin alu_op = ALU_OR;  is_mem_operand = 1'b1; next_state = ST_MEMRD; end
      OP_ADDI: begin alu_op = ALU_ADD; is_imm = 1'b1; next_state = ST_EXEC; end
      OP_SUBI: begin alu_op = ALU_SUB; is_imm = 1'b1; next_state = ST_EXEC; end
      OP_ANDI: begin alu_op = ALU_AND; is_imm = 1'b1; next_state = ST_EXEC; end
      OP_ORI:  begin alu_op = ALU_OR;  is_imm = 1'b1; next_state = ST_EXEC; end
      OP_LDA:  begin is_load = 1'b1; next_state = ST_MEMRD; end
      OP_STA:  next_state = ST_MEMWR;
      OP_JMP:  begin is_jump = 1'b1; next_state = ST_EXEC; end
      OP_JZ:   begin is_jz = 1'b1; next_state = ST_EXEC; end
      OP_HLT:  next_state = ST_HALT;
      default: next_state = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle fetch/decode/execute control unit: owns PC and IR, sequences
// the single-port memory and drives the ALU and accumulator controls.
module cu_sequencer #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DATA_W-1:0] acc,
  input  logic              acc_zero,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        alu_op,
  output logic              alu_en,
  output logic [DATA_W-1:0] alu_operand,
  output logic              acc_we,
  output logic              acc_sel,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              halted
);

  import cpu_pkg::*;

  state_t state, state_next;

  logic [3:0]  dec_opcode;
  logic [2:0]  dec_alu_op;
  logic        dec_is_mem_operand;
  logic        dec_is_imm;
  logic        dec_is_load;
  logic        dec_is_jump;
  logic        dec_is_jz;
  state_t      dec_next_state;
  logic        take_jump;
  logic [DATA_W-1:0] imm_operand;

  // In DECODE the instruction is still on mem_rdata; afterwards it lives in IR.
  assign dec_opcode  = (state == ST_DECODE) ? mem_rdata[DATA_W-1:DATA_W-4] : ir[DATA_W-1:DATA_W-4];
  assign take_jump   = (state == ST_EXEC) && (dec_is_jump || (dec_is_jz && acc_zero));
  assign imm_operand = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
  assign mem_wdata   = acc;

  cu_decode u_decode (
    .opcode         (dec_opcode),
    .alu_op         (dec_alu_op),
    .is_mem_operand (dec_is_mem_operand),
    .is_imm         (dec_is_imm),
    .is_load        (dec_is_load),
    .is_jump        (dec_is_jump),
    .is_jz          (dec_is_jz),
    .next_state     (dec_next_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      ir <= '0;
    end else if (state == ST_DECODE) begin
      ir <= mem_rdata;
      pc <= pc + 1'b1;
    end else if (take_jump) begin
      pc <= ir[ADDR_W-1:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:  state_next = run ? ST_DECODE : ST_FETCH;
      ST_DECODE: state_next = dec_next_state;
      ST_MEMRD:  state_next = ST_EXEC;
      ST_EXEC:   state_next = ST_FETCH;
      ST_MEMWR:  state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_FETCH;
    endcase
  end

  // The fetch strobe is gated by rst_n so nothing is requested while reset is held.
  always_comb begin
    mem_addr    = pc;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    alu_op      = ALU_NONE;
    alu_en      = 1'b0;
    alu_operand = '0;
    acc_we      = 1'b0;
    acc_sel     = 1'b0;
    halted      = 1'b0;
    case (state)
      ST_FETCH: mem_re = run & rst_n;
      ST_MEMRD: begin
        mem_addr = ir[ADDR_W-1:0];
        mem_re   = 1'b1;
      end
      ST_EXEC: begin
        if (dec_is_mem_operand || dec_is_imm) begin
          alu_en      = 1'b1;
          acc_we      = 1'b1;
          alu_op      = dec_alu_op;
          alu_operand = dec_is_imm ? imm_operand : mem_rdata;
        end else if (dec_is_load) begin
          acc_we  = 1'b1;
          acc_sel = 1'b1;
        end
      end
      ST_MEMWR: begin
        mem_addr = ir[ADDR_W-1:0];
        mem_we   = 1'b1;
      end
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer: an ISA-level interpreter predicts the
// bus/ALU events of each program and a monitor compares what the DUT shows.
module tb_cu_sequencer;

  localparam int EV_READ  = 0;
  localparam int EV_ALU   = 1;
  localparam int EV_LOAD  = 2;
  localparam int EV_STORE = 3;
  localparam int EV_HALT  = 4;

  typedef struct {
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
    logic [2:0] op;
    bit         is_fetch;
    int         gap;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] acc;
  logic       acc_zero;
  logic [7:0] mem_rdata;
  logic [3:0] mem_addr;
  logic       mem_re;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [2:0] alu_op;
  logic       alu_en;
  logic [7:0] alu_operand;
  logic       acc_we;
  logic       acc_sel;
  logic [3:0] pc;
  logic [7:0] ir;
  logic       halted;

  logic [7:0] prog    [16];
  logic [7:0] bus_mem [16];
  ev_t        exp_q[$];
  int         errors = 0;
  int         checks = 0;

  cu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .acc         (acc),
    .acc_zero    (acc_zero),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .alu_op      (alu_op),
    .alu_en      (alu_en),
    .alu_operand (alu_operand),
    .acc_we      (acc_we),
    .acc_sel     (acc_sel),
    .pc          (pc),
    .ir          (ir),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      default: return a;
    endcase
  endfunction

  // Memory (reloaded from prog while reset is held) and accumulator around the DUT.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) bus_mem[i] <= prog[i];
      mem_rdata <= '0;
    end else begin
      if (mem_re) mem_rdata <= bus_mem[mem_addr];
      if (mem_we) bus_mem[mem_addr] <= mem_wdata;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (acc_we) acc <= acc_sel ? mem_rdata : alu_ref(alu_op, acc, alu_operand);
  end

  assign acc_zero = (acc == 8'h00);

  function automatic bit check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void push_ev(input int kind, input logic [3:0] addr, input logic [7:0] data,
                                  input logic [2:0] op, input bit is_fetch, input int gap);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.op = op; e.is_fetch = is_fetch; e.gap = gap;
    exp_q.push_back(e);
  endfunction

  // Instruction-level interpreter; latency of each instruction sets the next fetch gap.
  function automatic void build_model(input int n_instr);
    logic [7:0] m [16];
    logic [7:0] a_acc = 8'h00;
    logic [3:0] p = 4'h0;
    int lat = 0;
    for (int i = 0; i < 16; i++) m[i] = prog[i];
    for (int k = 0; k < n_instr; k++) begin
      logic [7:0] instr;
      logic [3:0] opc, arg;
      push_ev(EV_READ, p, 8'h00, 3'd0, 1'b1, lat);
      instr = m[p];
      opc = instr[7:4];
      arg = instr[3:0];
      p = p + 4'd1;
      lat = 2;
      if (opc >= 4'd1 && opc <= 4'd4) begin
        push_ev(EV_READ, arg, 8'h00, 3'd0, 1'b0, 0);
        push_ev(EV_ALU, 4'h0, m[arg], opc[2:0], 1'b0, 0);
        a_acc = alu_ref(opc[2:0], a_acc, m[arg]);
        lat = 4;
      end else if (opc >= 4'd5 && opc <= 4'd8) begin
        logic [3:0] aop;
        aop = opc - 4'd4;
        push_ev(EV_ALU, 4'h0, {4'h0, arg}, aop[2:0], 1'b0, 0);
        a_acc = alu_ref(aop[2:0], a_acc, {4'h0, arg});
        lat = 3;
      end else if (opc == 4'h9) begin
        push_ev(EV_READ, arg, 8'h00, 3'd0, 1'b0, 0);
        push_ev(EV_LOAD, 4'h0, m[arg], 3'd0, 1'b0, 0);
        a_acc = m[arg];
        lat = 4;
      end else if (opc == 4'hA) begin
        push_ev(EV_STORE, arg, a_acc, 3'd0, 1'b0, 0);
        m[arg] = a_acc;
        lat = 3;
      end else if (opc == 4'hB) begin
        p = arg;
        lat = 3;
      end else if (opc == 4'hC) begin
        if (a_acc == 8'h00) p = arg;
        lat = 3;
      end else if (opc == 4'hF) begin
        push_ev(EV_HALT, p, 8'h00, 3'd0, 1'b0, 0);
        return;
      end
    end
  endfunction

  // Monitor: classify what the DUT presents each cycle and score it against the queue.
  initial begin
    int  cyc = 0;
    int  last_fetch = 0;
    bit  prev_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0; last_fetch = 0; prev_halt = 1'b0;
      end else begin
        int obs;
        ev_t e;
        bit ok;
        cyc++;
        obs = -1;
        if (mem_we)                    obs = EV_STORE;
        else if (acc_we)               obs = acc_sel ? EV_LOAD : EV_ALU;
        else if (mem_re)               obs = EV_READ;
        else if (halted && !prev_halt) obs = EV_HALT;
        prev_halt = halted;
        if (obs >= 0 && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (!check_output("event_kind", obs, e.kind)) begin
            exp_q.delete();
          end else begin
            case (obs)
              EV_READ: begin
                ok = check_output("read_addr", mem_addr, e.addr);
                ok = check_output("read_no_we", mem_we, 1'b0);
                if (e.is_fetch) begin
                  ok = check_output("fetch_pc", pc, e.addr);
                  if (e.gap != 0) ok = check_output("fetch_gap", cyc - last_fetch, e.gap);
                  last_fetch = cyc;
                end
              end
              EV_ALU: begin
                ok = check_output("alu_op", alu_op, e.op);
                ok = check_output("alu_operand", alu_operand, e.data);
                ok = check_output("alu_en", alu_en, 1'b1);
              end
              EV_LOAD: begin
                ok = check_output("load_alu_en", alu_en, 1'b0);
                ok = check_output("load_data", mem_rdata, e.data);
              end
              EV_STORE: begin
                ok = check_output("store_addr", mem_addr, e.addr);
                ok = check_output("store_data", mem_wdata, e.data);
                ok = check_output("store_no_re", mem_re, 1'b0);
              end
              default: ok = check_output("halt_pc", pc, e.addr);
            endcase
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input logic rst_val, input logic run_val);
    @(posedge clk);
    #1;
    rst_n = rst_val;
    run   = run_val;
  endtask

  task automatic run_program(input int n_instr);
    apply_stimulus(1'b0, 1'b1);
    exp_q.delete();
    build_model(n_instr);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    for (int c = 0; c < 600 && exp_q.size() != 0; c++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_timeout: %0d events pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;

    // Reset values with run already high.
    rst_n = 1'b0;
    run   = 1'b1;
    @(negedge clk);
    ok = check_output("rst_mem_re", mem_re, 1'b0);
    ok = check_output("rst_mem_we", mem_we, 1'b0);
    ok = check_output("rst_alu_en", alu_en, 1'b0);
    ok = check_output("rst_acc_we", acc_we, 1'b0);
    ok = check_output("rst_alu_op", alu_op, 3'b000);
    ok = check_output("rst_alu_operand", alu_operand, 8'h00);
    ok = check_output("rst_pc", pc, 4'h0);
    ok = check_output("rst_ir", ir, 8'h00);
    ok = check_output("rst_halted", halted, 1'b0);

    // ADDI, SUB [E], LDA [F], STA [E], JZ not taken/taken, JMP, illegal opcode.
    prog = '{8'h53, 8'h2E, 8'h9F, 8'hAE, 8'hC9, 8'h70, 8'hC9, 8'hF0,
             8'hF0, 8'hBD, 8'hF0, 8'hF0, 8'hF0, 8'hD0, 8'h07, 8'h42};
    run_program(24);

    // JMP 0 placed at address F, entered via JMP F from address 0.
    prog = '{8'hBF, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
             8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hB0};
    run_program(10);

    // Halt: no strobes afterwards even with run high, then async reset release of halt.
    for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
    prog[0] = 8'h51;
    run_program(5);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ok = check_output("halt_no_re", mem_re, 1'b0);
    end
    ok = check_output("halt_flag", halted, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    ok = check_output("async_rst_pc", pc, 4'h0);
    ok = check_output("async_rst_halted", halted, 1'b0);

    // run low in FETCH: no read, pc holds.
    prog[0] = 8'h53;
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ok = check_output("stall_no_re", mem_re, 1'b0);
      ok = check_output("stall_pc", pc, 4'h0);
    end

    // Reset dropped during the DECODE of a STA: the write must never appear.
    prog[0] = 8'hAE;
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    run   = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ok = check_output("abort_no_we", mem_we, 1'b0);
      if (c == 2) rst_n = 1'b1;
    end

    // Random programs against the interpreter.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      run_program(20);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
